// File: rtl/multiword_add_pkg.sv
// Shared types and sizing helpers for the sequential multi-word adder.
// Contents: state_t (IDLE/RUN/DONE), WORD_W (slice width), idx_w() word-index width.
package multiword_add_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word-index width: clog2(nwords), never below one bit.
    function automatic int unsigned idx_w(input int unsigned nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/add16_cla.sv
// 16-bit two-level carry-lookahead adder slice (four 4-bit groups).
// Ports: a, b     - 16-bit addends
//        cin      - carry in
//        sum      - 16-bit result
//        cout     - carry out
module add16_cla
    import multiword_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] c;
    logic [3:0]        gg;
    logic [3:0]        pg;
    logic [3:0]        gc;

    assign g = a & b;
    assign p = a ^ b;

    // Group-level lookahead: carries into each 4-bit group straight from cin.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (pg[0] & cin);
    assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                 | (pg[2] & pg[1] & pg[0] & cin);
    assign cout  = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                 | (pg[3] & pg[2] & pg[1] & gg[0]) | (&pg & cin);

    // Bit-level lookahead inside each group from the group carry.
    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int unsigned B0 = 4 * k;
        assign pg[k] = &p[B0 +: 4];
        assign gg[k] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                     | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
        assign c[B0]   = gc[k];
        assign c[B0+1] = g[B0] | (p[B0] & gc[k]);
        assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & gc[k]);
        assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                       | (p[B0+2] & p[B0+1] & p[B0] & gc[k]);
    end

    assign sum = p ^ c;

endmodule

// File: rtl/multiword_adder_seq.sv
// Sequential multi-precision adder: adds two 16*NWORDS-bit operands one
// 16-bit word per cycle through a single reused add16_cla slice, LS word first.
// Optional macro MWADD_SUBTRACT_EN adds the `sub` port (A - B via ~B and carry-in 1).
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready, a, b, cin, [sub]  - operand handshake (in_ready high in IDLE)
//        out_valid/out_ready, sum, cout, ovf  - result handshake (held while in DONE)
//        busy                                 - high in RUN or DONE
module multiword_adder_seq
    import multiword_add_pkg::*;
#(
    parameter int unsigned NWORDS = 4
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] a,
    input  logic [WORD_W*NWORDS-1:0] b,
    input  logic                     cin,
`ifdef MWADD_SUBTRACT_EN
    input  logic                     sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy
);

    localparam int unsigned W     = WORD_W * NWORDS;
    localparam int unsigned IDX_W = idx_w(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t                         state_q;
    state_t                         state_d;
    logic [NWORDS-1:0][WORD_W-1:0]  a_q;
    logic [NWORDS-1:0][WORD_W-1:0]  b_q;
    logic [NWORDS-1:0][WORD_W-1:0]  sum_q;
    logic                           carry_q;
    logic [IDX_W-1:0]               idx_q;
    logic [W-1:0]                   b_eff_c;
    logic                           cin_eff_c;
    logic [WORD_W-1:0]              slice_sum_c;
    logic                           slice_cout_c;
    logic                           load_c;
    logic                           step_c;
    logic                           last_c;

    // Operand actually added and carry into word 0.
`ifdef MWADD_SUBTRACT_EN
    assign b_eff_c   = sub ? ~b : b;
    assign cin_eff_c = sub | cin;
`else
    assign b_eff_c   = b;
    assign cin_eff_c = cin;
`endif

    // Single slice, fed by the word selected with idx_q.
    add16_cla u_slice (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum_c),
        .cout (slice_cout_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load_c  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                if (idx_q == LAST_IDX) begin
                    last_c  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with handshake/status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            busy      <= (state_d != ST_IDLE);
        end
    end

    // Operand capture and word-serial accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (load_c) begin
            a_q     <= a;
            b_q     <= b_eff_c;
            carry_q <= cin_eff_c;
            idx_q   <= '0;
        end else if (step_c) begin
            sum_q[idx_q] <= slice_sum_c;
            carry_q      <= slice_cout_c;
            if (last_c) begin
                cout <= slice_cout_c;
                // Like-signed operands whose result sign differs.
                ovf  <= (a_q[NWORDS-1][WORD_W-1] == b_q[NWORDS-1][WORD_W-1])
                     && (slice_sum_c[WORD_W-1] != a_q[NWORDS-1][WORD_W-1]);
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign sum = sum_q;

endmodule
